// File: rtl/cmp_pkg.sv
// Shared types and the per-bit decision rule for the serial magnitude comparator.
// The comparator scans MSB-first, so the first differing bit settles the result.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } cmp_state_e;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_EQ,
      RES_LT,
      RES_GT
   } cmp_result_e;

   // The sign bit carries negative weight, so a 1 there makes the operand smaller.
   function automatic cmp_result_e bit_decide(
      input logic a_bit,
      input logic b_bit,
      input logic is_sign_bit,
      input logic is_signed
   );
      if (a_bit == b_bit) begin
         return RES_NONE;
      end
      if (is_signed && is_sign_bit) begin
         return a_bit ? RES_LT : RES_GT;
      end
      return a_bit ? RES_GT : RES_LT;
   endfunction

endpackage

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with valid/ready handshakes on both sides.
// One bit per clock; optionally stops at the first differing bit.
module serial_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             res_eq,
   output logic             res_lt,
   output logic             res_gt,
   output logic             busy
);

   localparam int            CW      = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   cmp_state_e    r_state;
   cmp_state_e    w_state_nxt;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic          r_signed;
   logic [CW-1:0] r_cnt;
   cmp_result_e   r_result;

   cmp_result_e   w_bit_res;
   logic          w_record;
   logic          w_scan_last;

   // The counter sits at CNT_TOP only on the first scan cycle, i.e. the sign bit.
   assign w_bit_res   = bit_decide(r_sh_a[WIDTH-1], r_sh_b[WIDTH-1],
                                   (r_cnt == CNT_TOP), r_signed);
   assign w_record    = (r_state == SCAN) && (r_result == RES_NONE) &&
                        (w_bit_res != RES_NONE);
   assign w_scan_last = (r_cnt == '0) || (EARLY_EXIT && w_record);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)    w_state_nxt = SCAN;
         SCAN:    if (w_scan_last) w_state_nxt = DONE;
         DONE:    if (out_ready)   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: the datapath is small, so it is fully reset; a discarded compare
   // leaves no stale operand bits behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sh_a   <= '0;
         r_sh_b   <= '0;
         r_signed <= 1'b0;
         r_cnt    <= '0;
         r_result <= RES_NONE;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_sh_a   <= in_a;
                  r_sh_b   <= in_b;
                  r_signed <= in_signed;
                  r_cnt    <= CNT_TOP;
                  r_result <= RES_NONE;
               end
            end
            SCAN: begin
               if (w_record) begin
                  r_result <= w_bit_res;
               end else if (w_scan_last && (r_result == RES_NONE)) begin
                  r_result <= RES_EQ;
               end
               r_sh_a <= {r_sh_a[WIDTH-2:0], 1'b0};
               r_sh_b <= {r_sh_b[WIDTH-2:0], 1'b0};
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_result <= RES_NONE;
               end
            end
            default: r_result <= RES_NONE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);

   // With fixed latency a decision is recorded mid-scan, so results are gated by out_valid.
   assign res_eq = out_valid && (r_result == RES_EQ);
   assign res_lt = out_valid && (r_result == RES_LT);
   assign res_gt = out_valid && (r_result == RES_GT);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench: an early-exit and a fixed-latency comparator share one stimulus stream.
// Expected result and latency are pushed at accept and popped when both results appear.
module tb_serial_mag_comparator;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_signed;
   logic         out_ready;

   logic ee_in_ready, ee_out_valid, ee_eq, ee_lt, ee_gt, ee_busy;
   logic fx_in_ready, fx_out_valid, fx_eq, fx_lt, fx_gt, fx_busy;

   typedef struct packed {
      logic [2:0] res;
      logic [7:0] lat_ee;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(ee_in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(ee_out_valid), .out_ready(out_ready),
      .res_eq(ee_eq), .res_lt(ee_lt), .res_gt(ee_gt), .busy(ee_busy)
   );

   serial_mag_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_fx (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(fx_in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(fx_out_valid), .out_ready(out_ready),
      .res_eq(fx_eq), .res_lt(fx_lt), .res_gt(fx_gt), .busy(fx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference result, one-hot {eq, lt, gt}.
   function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
      logic lt;
      if (a == b) return 3'b100;
      lt = s ? ($signed(a) < $signed(b)) : (a < b);
      return lt ? 3'b010 : 3'b001;
   endfunction

   // Early-exit latency: edges to reach the first differing bit, or W when equal.
   function automatic logic [7:0] model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
      for (int i = W - 1; i >= 0; i--) begin
         if (a[i] != b[i]) return 8'(W - i);
      end
      return 8'(W);
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_ee_idle"}, {ee_in_ready, ee_out_valid, ee_busy, ee_eq, ee_lt, ee_gt}, 6'b100000);
      check({tag, "_fx_idle"}, {fx_in_ready, fx_out_valid, fx_busy, fx_eq, fx_lt, fx_gt}, 6'b100000);
   endtask

   // One transaction; optionally hold out_ready low and poke in_valid while in DONE.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int hold, input bit poke);
      exp_t       e;
      int         edges;
      int         lat_ee;
      int         lat_fx;
      logic [3:0] snap_ee;
      logic [3:0] snap_fx;
      @(negedge clk);
      check("pre_accept_ready", {ee_in_ready, fx_in_ready}, 2'b11);
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_valid  = 1'b1;
      sb.push_back('{res: model_res(a, b, s), lat_ee: model_lat(a, b)});
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_signed = ~s;
      edges  = 0;
      lat_ee = -1;
      lat_fx = -1;
      snap_ee = '0;
      while ((lat_ee < 0 || lat_fx < 0) && edges < W + 4) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (lat_ee >= 0) begin
            check("ee_held_during_scan", {ee_out_valid, ee_eq, ee_lt, ee_gt}, snap_ee);
         end else if (ee_out_valid) begin
            lat_ee  = edges;
            snap_ee = {ee_out_valid, ee_eq, ee_lt, ee_gt};
         end else begin
            check("ee_res_quiet", {ee_eq, ee_lt, ee_gt}, 3'b000);
         end
         if (fx_out_valid && lat_fx < 0) begin
            lat_fx = edges;
         end else if (!fx_out_valid) begin
            check("fx_res_quiet_busy", {fx_eq, fx_lt, fx_gt, fx_busy, fx_in_ready}, 5'b00010);
         end
      end
      e = sb.pop_front();
      check("ee_latency", lat_ee, {24'd0, e.lat_ee});
      check("fx_latency", lat_fx, W);
      check("ee_result", {ee_eq, ee_lt, ee_gt}, e.res);
      check("fx_result", {fx_eq, fx_lt, fx_gt}, e.res);
      snap_ee = {ee_out_valid, ee_eq, ee_lt, ee_gt};
      snap_fx = {fx_out_valid, fx_eq, fx_lt, fx_gt};
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         check("ee_backpressure_hold", {ee_out_valid, ee_eq, ee_lt, ee_gt}, snap_ee);
         check("fx_backpressure_hold", {fx_out_valid, fx_eq, fx_lt, fx_gt}, snap_fx);
         check("ready_low_in_done", {ee_in_ready, fx_in_ready}, 2'b00);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      // A pending in_valid during the out handshake must not be accepted on that edge.
      check_idle("release");
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_signed = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_idle("reset");

      run_op(8'h80, 8'h00, 1'b0, 0, 1'b0);
      run_op(8'hA5, 8'hA4, 1'b0, 0, 1'b0);
      run_op(8'h80, 8'h01, 1'b1, 0, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
      run_op(8'hFF, 8'hFE, 1'b1, 0, 1'b0);
      run_op(8'h3C, 8'h3C, 1'b0, 0, 1'b0);
      run_op(8'h3C, 8'h3C, 1'b1, 0, 1'b0);
      run_op(8'h00, 8'hFF, 1'b1, 0, 1'b0);
      run_op(8'h7F, 8'h80, 1'b1, 0, 1'b0);
      run_op(8'h01, 8'h02, 1'b0, 0, 1'b0);

      run_op(8'hC3, 8'hC7, 1'b1, 5, 1'b1);
      run_op(8'h5A, 8'h59, 1'b0, 0, 1'b0);

      // Reset lands on the third scan edge: the early-exit decision edge for this pair.
      @(negedge clk);
      in_a      = 8'h12;
      in_b      = 8'h34;
      in_signed = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("mid_scan_no_valid", {ee_out_valid, fx_out_valid}, 2'b00);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_idle("mid_reset");
      @(posedge clk);
      @(negedge clk);
      check_idle("post_reset");
      run_op(8'h34, 8'h12, 1'b0, 0, 1'b0);

      for (int n = 0; n < 8; n++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = (n % 3 == 0) ? ra : W'($urandom);
         run_op(ra, rb, 1'(n & 1), n % 2, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator. Successor to the single-bit equality comparator.
- Accepts two WIDTH-bit operands over a valid/ready handshake and scans them serially, MSB-first, one bit per clock, to save area.
- Reports equal / less-than / greater-than, for unsigned or two's-complement signed operands, on a held valid/ready output.
- Sits between register-file readout and control logic that tolerates multi-cycle compare latency.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..64.
- EARLY_EXIT, 1: 1 = finish as soon as the first differing bit is found; 0 = always scan all WIDTH bits (fixed latency).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_signed  input  1  1 = treat operands as two's complement; sampled on accept.
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- res_eq  output  1  A == B.
- res_lt  output  1  A < B.
- res_gt  output  1  A > B.
- busy  output  1  high in SCAN or DONE.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous, active-low (sampled only on the rising clk edge).
- Reset (rst_n low at an edge): state IDLE, in_ready=1, out_valid=0, res_eq/lt/gt=0, busy=0, counter=0, shift registers cleared.
- States:
  - IDLE: in_ready=1. When in_valid&&in_ready at an edge, load sh_a<=in_a, sh_b<=in_b, latch in_signed, clear results, counter<=WIDTH-1, go to SCAN.
  - SCAN: in_ready=0. Each edge examines the MSBs of sh_a and sh_b.
    - If they differ and no decision has been recorded yet, record the decision:
      - unsigned, or signed at a non-sign bit: a_bit=1 gives gt, else lt;
      - signed at the sign bit (first SCAN cycle): a_bit=1 gives lt, else gt.
    - Then shift both registers left by 1 and decrement the counter.
    - Leave SCAN for DONE when counter==0, or, with EARLY_EXIT=1, at the edge where the decision is recorded.
    - If no decision has been recorded on leaving SCAN, res_eq=1.
  - DONE: out_valid=1 and exactly one of res_eq/lt/gt is high. Outputs hold stable while out_ready=0. On out_ready high at an edge, clear results and out_valid and go to IDLE.
- Latency, counted in edges from the accept edge to out_valid rising:
  - EARLY_EXIT=0: always WIDTH.
  - EARLY_EXIT=1: k+1, where k is the number of leading equal bits (k=WIDTH-1 at most), or WIDTH when the operands are equal.
- Throughput: the earliest next accept is one edge after the out handshake; there is no accept in the same cycle as the out handshake.
- in_valid, in_a, in_b and in_signed are ignored outside IDLE; the operands need not be held after acceptance.
- A result is never dropped; out_valid never deasserts without out_ready.
- res_* are all 0 whenever out_valid=0.
- Reset mid-SCAN or mid-DONE: the in-flight comparison is discarded and the next edge is in IDLE with reset values. Reset has priority over all handshakes.
- Counter width: $clog2(WIDTH). No arithmetic overflow is possible.

Decomposition:
- Package cmp_pkg:
  - typedef enum logic [1:0] cmp_state_e {IDLE, SCAN, DONE};
  - typedef enum logic [1:0] cmp_result_e {RES_NONE, RES_EQ, RES_LT, RES_GT};
  - function bit_decide(a_bit, b_bit, is_sign_bit, is_signed), returning cmp_result_e.
- No sub-module: a single FSM with a datapath is sufficient.
- The one-hot res_* outputs are decoded from a registered cmp_result_e.

Test Plan:
- Reset and idle: rst_n=0 for 2 edges, then 1 -> in_ready=1, out_valid=0, res_*=0, busy=0.
- Unsigned early exit: WIDTH=8, EARLY_EXIT=1, a=0x80, b=0x00, unsigned -> out_valid 1 edge after accept, res_gt=1. Then a=0xA5, b=0xA4 -> out_valid 8 edges after accept, res_gt=1.
- Signed versus unsigned: a=0x80, b=0x01 with in_signed=1 -> res_lt=1; same operands with in_signed=0 -> res_gt=1. a=0xFF, b=0xFE signed -> res_gt=1.
- Equality and fixed latency: EARLY_EXIT=0, a=b=0x3C -> res_eq=1 exactly 8 edges after accept. Also a=0x80, b=0x00 -> still 8 edges, res_gt=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and res_* stable; a new in_valid pulse is ignored (in_ready=0). Raise out_ready -> IDLE next edge, then accept the new pair.
- Reset mid-operation: assert rst_n=0 on the 3rd SCAN edge of a=0x12, b=0x34 -> next edge IDLE, no out_valid pulse. A subsequent a=0x34, b=0x12 -> res_gt=1 with normal latency.
